// File: rtl/mcu_core_fsm.sv
// mcu_core_fsm: multi-cycle accumulator MCU core sharing one req/ack word-addressed memory for fetch and data
module mcu_core_fsm #(
  parameter int DW = 16,
  parameter int AW = 12,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset_n,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] acc,
  output logic [1:0]    flags,
  output logic          halted
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, MEM, HALT} state_t;
  state_t state;
  logic [DW-1:0] ir;
  logic [3:0] op;
  logic [AW-1:0] c;
  logic is_mem, n, z;
  assign op = ir[DW-1:DW-4];
  assign c = ir[AW-1:0];
  assign is_mem = op inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9};
  always_comb begin
    mem_req = state == FETCH || state == MEM;
    mem_we = state == MEM && op == 4'h3;
    mem_addr = state == MEM ? c : pc;
    mem_wdata = acc;
    flags = {n, z};
    halted = state == HALT;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      acc <= '0;
      n <= 1'b0;
      z <= 1'b0;
      ir <= '0;
    end else
      case (state)
        IDLE: state <= FETCH;
        FETCH:
          if (mem_ack) begin
            ir <= mem_rdata;
            pc <= pc + 1'b1;
            state <= DECODE;
          end
        DECODE: begin
          state <= op == 4'hF ? HALT : is_mem ? MEM : FETCH;
          case (op)
            4'h2: pc <= c;
            4'h5: if (z) pc <= c;
            4'hA: if (n) pc <= c;
            4'hB: acc <= acc << 1;
            4'hC: acc <= acc >> 1;
            4'hD: acc <= DW'(c);
            default: ;
          endcase
        end
        MEM:
          if (mem_ack) begin
            state <= FETCH;
            case (op)
              4'h0: acc <= mem_rdata;
              4'h1: acc <= acc + mem_rdata;
              4'h4: begin
                n <= mem_rdata < acc;
                z <= mem_rdata == acc;
              end
              4'h6: acc <= acc - mem_rdata;
              4'h7: acc <= acc & mem_rdata;
              4'h8: acc <= acc | mem_rdata;
              4'h9: acc <= acc ^ mem_rdata;
              default: ;
            endcase
          end
        default: state <= HALT;
      endcase
endmodule
